// File: rtl/testcase_1_pkg.sv
// Shared types and constants for the K=3, rate-1/2 hard-decision Viterbi decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, block length, generator polynomials, path-metric
// width and start value, and helpers that compute expected symbols and
// Hamming branch metrics.
package testcase_1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACS  = 2'd1,
        ST_TB   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int N_SYM = 8;

    // Generators applied to the register {u, s1, s2}.
    localparam logic [2:0] GEN_C0 = 3'b111;
    localparam logic [2:0] GEN_C1 = 3'b101;

    // 31 start offset + 8 symbols * 2 worst-case branch cost = 47 < 64.
    localparam int METRIC_W = 6;
    localparam logic [METRIC_W-1:0] METRIC_INIT = 6'd31;

    typedef logic [METRIC_W-1:0] metric_t;
    typedef metric_t [3:0]       metric_vec_t;

    // Symbol the encoder emits for input u from state {s1, s2}; {c0, c1}.
    function automatic logic [1:0] expected_sym(input logic u, input logic s1, input logic s2);
        expected_sym = {^({u, s1, s2} & GEN_C0), ^({u, s1, s2} & GEN_C1)};
    endfunction

    // Hamming distance between two 2-bit symbols (0..2).
    function automatic logic [1:0] branch_metric(input logic [1:0] rx, input logic [1:0] ex);
        logic [1:0] d;
        d = rx ^ ex;
        branch_metric = {d[1] & d[0], d[1] ^ d[0]};
    endfunction

endpackage

// File: rtl/testcase_1_if.sv
// Request/result bundle between a block driver and the Viterbi decoder.
// Latency: n/a (wiring only).
// Backpressure: none; start is a level request, done is held until start drops.
//
// Signals: start/data driven by the master, data_out/done driven by the decoder.
interface testcase_1_if
    import testcase_1_pkg::*;
#(
    parameter int W_IN  = 2 * N_SYM,
    parameter int W_OUT = N_SYM
);
    logic             start;
    logic [W_IN-1:0]  data;
    logic [W_OUT-1:0] data_out;
    logic             done;

    modport master (output start, data, input  data_out, done);
    modport slave  (input  start, data, output data_out, done);
endinterface

// File: rtl/testcase_1_acs.sv
// One trellis step: next path metrics and survivor bits for all four states.
// Latency: combinational.
// Backpressure: none; evaluated every cycle, the caller decides when to commit.
//
// Ports: i_metric (current metrics), i_sym (received {c0,c1}),
//        o_metric (next metrics), o_surv (per-state survivor = s2 of chosen predecessor).
module testcase_1_acs
    import testcase_1_pkg::*;
(
    input  metric_vec_t i_metric,
    input  logic [1:0]  i_sym,
    output metric_vec_t o_metric,
    output logic [3:0]  o_surv
);

    metric_t w_cand0 [4];
    metric_t w_cand1 [4];

    function automatic metric_t path_metric(input metric_t m, input logic [1:0] sym,
                                            input logic u, input logic s1, input logic s2);
        path_metric = m + {{(METRIC_W-2){1'b0}}, branch_metric(sym, expected_sym(u, s1, s2))};
    endfunction

    // Next state {u, a} is reached from {a, 0} and {a, 1}. Candidate 0 is the
    // lower state index, so it wins ties.
    always_comb begin
        o_metric = '0;
        o_surv   = '0;
        w_cand0  = '{default: '0};
        w_cand1  = '{default: '0};
        for (int ns = 0; ns < 4; ns++) begin
            w_cand0[ns] = path_metric(i_metric[{ns[0], 1'b0}], i_sym, ns[1], ns[0], 1'b0);
            w_cand1[ns] = path_metric(i_metric[{ns[0], 1'b1}], i_sym, ns[1], ns[0], 1'b1);
            if (w_cand1[ns] < w_cand0[ns]) begin
                o_metric[ns] = w_cand1[ns];
                o_surv[ns]   = 1'b1;
            end else begin
                o_metric[ns] = w_cand0[ns];
                o_surv[ns]   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/testcase_1.sv
// Hard-decision Viterbi decoder, K=3 rate-1/2 (g=7,5), 16-bit block -> 8-bit message.
// Latency: o_done rises on the 17th edge counting the edge that samples i_start (1 load + 8 ACS + 8 TB).
// Backpressure: i_start is ignored mid-decode; o_done/o_data held while i_start stays high.
//
// Ports: i_clk, i_rst_n (async active-low), i_start (level request), i_data (coded block,
//        symbol 0 in the top two bits), o_data (decoded byte, first message bit in MSB),
//        o_done (result valid, held until i_start drops).
module testcase_1
    import testcase_1_pkg::*;
#(
    parameter int SIZE_DATA_IN  = 16,
    parameter int SIZE_DATA_OUT = 8
)(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic [SIZE_DATA_IN-1:0]  i_data,
    output logic [SIZE_DATA_OUT-1:0] o_data,
    output logic                     o_done
);

    localparam logic [2:0] LAST_STEP = 3'(N_SYM - 1);

    state_e                   r_state;
    logic [SIZE_DATA_IN-1:0]  r_piso;
    metric_vec_t              r_metric;
    logic [3:0]               r_surv [N_SYM];
    logic [2:0]               r_step;
    logic [1:0]               r_tb_state;
    logic [SIZE_DATA_OUT-1:0] r_sipo;
    logic [SIZE_DATA_OUT-1:0] r_data;
    logic                     r_done;
    logic                     r_armed;

    metric_vec_t w_metric_nxt;
    logic [3:0]  w_surv;
    logic [1:0]  w_min_state;
    metric_t     w_min_val;
    logic        w_surv_bit;

    // Probe points: symbol entering ACS and bit leaving traceback.
    logic [1:0] w_data_PISO;
    logic       w_data_SIPO;

    assign w_data_PISO = r_piso[SIZE_DATA_IN-1 -: 2];
    assign w_data_SIPO = r_tb_state[1];
    assign w_surv_bit  = r_surv[r_step][r_tb_state];

    assign o_data = r_data;
    assign o_done = r_done;

    testcase_1_acs u_acs (
        .i_metric (r_metric),
        .i_sym    (w_data_PISO),
        .o_metric (w_metric_nxt),
        .o_surv   (w_surv)
    );

    // Traceback start: smallest final metric, strict compare keeps the lowest index on ties.
    always_comb begin
        w_min_state = 2'd0;
        w_min_val   = w_metric_nxt[0];
        for (int i = 1; i < 4; i++) begin
            if (w_metric_nxt[i] < w_min_val) begin
                w_min_val   = w_metric_nxt[i];
                w_min_state = 2'(i);
            end
        end
    end

    // r_armed is set whenever i_start is seen low, so a request that was already
    // high across reset release (or still high from the last decode) cannot restart.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_piso     <= '0;
            r_metric   <= '0;
            r_step     <= '0;
            r_tb_state <= '0;
            r_sipo     <= '0;
            r_data     <= '0;
            r_done     <= 1'b0;
            r_armed    <= 1'b0;
            for (int i = 0; i < N_SYM; i++) begin
                r_surv[i] <= '0;
            end
        end else begin
            if (!i_start) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_start && r_armed) begin
                        r_piso   <= i_data;
                        r_metric <= {METRIC_INIT, METRIC_INIT, METRIC_INIT, metric_t'(0)};
                        r_step   <= '0;
                        r_armed  <= 1'b0;
                        r_state  <= ST_ACS;
                    end
                end
                ST_ACS: begin
                    r_metric       <= w_metric_nxt;
                    r_surv[r_step] <= w_surv;
                    r_piso         <= r_piso << 2;
                    if (r_step == LAST_STEP) begin
                        // r_step stays at the last column: traceback walks it back down.
                        r_tb_state <= w_min_state;
                        r_state    <= ST_TB;
                    end else begin
                        r_step <= r_step + 3'd1;
                    end
                end
                ST_TB: begin
                    r_sipo     <= {w_data_SIPO, r_sipo[SIZE_DATA_OUT-1:1]};
                    r_tb_state <= {r_tb_state[0], w_surv_bit};
                    if (r_step == 3'd0) begin
                        r_data  <= {w_data_SIPO, r_sipo[SIZE_DATA_OUT-1:1]};
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_step <= r_step - 3'd1;
                    end
                end
                ST_DONE: begin
                    if (!i_start) begin
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_testcase_1.sv
// Bench for the Viterbi decoder: directed vectors, random blocks, hold/reset/ignore scenarios.
// Latency: expects o_done 16 edges after the load edge (17 edges including it).
// Backpressure: holds i_start across DONE to exercise the hold behaviour.
module tb_testcase_1;

    localparam int unsigned LOAD_TO_DONE = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    testcase_1_if #(.W_IN(16), .W_OUT(8)) bus ();

    testcase_1 #(.SIZE_DATA_IN(16), .SIZE_DATA_OUT(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (bus.start),
        .i_data  (bus.data),
        .o_data  (bus.data_out),
        .o_done  (bus.done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  data;
        int unsigned start_cyc;
        string       name;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Encoder used only to build stimulus: message bit 7 goes in first.
    function automatic logic [15:0] encode(input logic [7:0] msg);
        logic s1, s2, u;
        logic [15:0] code;
        s1 = 1'b0; s2 = 1'b0; code = '0;
        for (int t = 0; t < 8; t++) begin
            u = msg[7-t];
            code[15-2*t]   = u ^ s1 ^ s2;
            code[14-2*t]   = u ^ s2;
            s2 = s1;
            s1 = u;
        end
        return code;
    endfunction

    // Reference decoder: carries every survivor's full message (register exchange)
    // instead of storing decisions and tracing back.
    function automatic logic [7:0] viterbi_ref(input logic [15:0] code);
        int m[4];
        int nm[4];
        logic [7:0] p[4];
        logic [7:0] np[4];
        logic [1:0] sym;
        int u, a, prev, c0, c1, d, best, bp, win;
        m[0] = 0; m[1] = 31; m[2] = 31; m[3] = 31;
        for (int i = 0; i < 4; i++) p[i] = 8'h00;
        for (int t = 0; t < 8; t++) begin
            sym = code[15-2*t -: 2];
            for (int ns = 0; ns < 4; ns++) begin
                u = ns / 2;
                a = ns % 2;
                best = 1000;
                bp = 0;
                for (int s2 = 0; s2 < 2; s2++) begin
                    prev = 2 * a + s2;
                    c0 = u ^ a ^ s2;
                    c1 = u ^ s2;
                    d = ((c0 != int'(sym[1])) ? 1 : 0) + ((c1 != int'(sym[0])) ? 1 : 0);
                    if (m[prev] + d < best) begin
                        best = m[prev] + d;
                        bp = prev;
                    end
                end
                nm[ns] = best;
                np[ns] = p[bp] | (8'(u) << (7 - t));
            end
            for (int i = 0; i < 4; i++) begin
                m[i] = nm[i];
                p[i] = np[i];
            end
        end
        win = 0;
        for (int i = 1; i < 4; i++) if (m[i] < m[win]) win = i;
        return p[win];
    endfunction

    // Monitor: every rising o_done must match the oldest outstanding request.
    logic done_q = 1'b0;
    always @(negedge clk) begin
        if (bus.done && !done_q) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got o_data %0h, expected no completion", bus.data_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_data"}, 32'(bus.data_out), 32'(e.data));
                check({e.name, "_latency"}, cyc - e.start_cyc, LOAD_TO_DONE);
            end
        end
        done_q <= bus.done;
    end

    task automatic push_exp(input logic [7:0] data, input string name);
        exp_t e;
        e.data = data;
        e.start_cyc = cyc + 1;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no o_done after %0d cycles, expected o_done", name, n);
        end
    endtask

    task automatic run_decode(input logic [15:0] code, input logic [7:0] exp, input string name,
                              input bit probe, input int hold);
        @(negedge clk);
        bus.data = code;
        bus.start = 1'b1;
        push_exp(exp, name);
        if (probe) begin
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                check($sformatf("piso_sym%0d", k), 32'(dut.w_data_PISO), 32'(code[15-2*k -: 2]));
            end
        end
        wait_done(name);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({name, "_hold_done"}, 32'(bus.done), 32'd1);
            check({name, "_hold_data"}, 32'(bus.data_out), 32'(exp));
        end
        bus.start = 1'b0;
        @(negedge clk);
        check({name, "_done_drop"}, 32'(bus.done), 32'd0);
        check({name, "_data_kept"}, 32'(bus.data_out), 32'(exp));
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  msg;
        logic [15:0] code;

        bus.start = 1'b0;
        bus.data  = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_data", 32'(bus.data_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors.
        run_decode(16'h0000, 8'h00, "zero", 1'b0, 0);
        run_decode(16'hDAAA, 8'hFF, "ones", 1'b0, 0);
        run_decode(16'hE2F8, 8'hA5, "a5",   1'b1, 0);
        run_decode(16'hE6F8, 8'hA5, "a5_err", 1'b0, 0);

        // Held start after completion: stays in DONE, no restart, result kept.
        run_decode(16'hDAAA, 8'hFF, "hold", 1'b0, 6);
        repeat (3) @(negedge clk);
        check("idle_data_kept", 32'(bus.data_out), 32'hFF);

        // Reset in the middle of ACS clears outputs without a clock edge.
        @(negedge clk);
        bus.data = 16'hE2F8;
        bus.start = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_data", 32'(bus.data_out), 32'd0);
        check("midrst_piso", 32'(dut.w_data_PISO), 32'd0);
        // Start still high across release: must not launch a decode.
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("no_stale_start", 32'(bus.done), 32'd0);
        bus.start = 1'b0;
        @(negedge clk);
        run_decode(16'hE2F8, 8'hA5, "post_rst", 1'b0, 0);

        // i_start / i_data wiggling during ACS and TB must not disturb the result.
        @(negedge clk);
        bus.data = 16'hE2F8;
        bus.start = 1'b1;
        push_exp(8'hA5, "ignore");
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            bus.data = 16'($urandom);
            bus.start = (k >= 3 && k <= 13) ? 1'(k % 2) : 1'b1;
        end
        wait_done("ignore");
        bus.start = 1'b0;
        repeat (2) @(negedge clk);

        // Random encoded messages, every other one with a single flipped bit.
        for (int i = 0; i < 20; i++) begin
            msg  = 8'($urandom);
            code = encode(msg);
            if (i % 2 == 1) code[$urandom_range(15, 0)] ^= 1'b1;
            run_decode(code, viterbi_ref(code), $sformatf("rnd_msg%0d", i), 1'b0, 0);
        end

        // Arbitrary received blocks, including heavily corrupted ones.
        for (int i = 0; i < 10; i++) begin
            code = 16'($urandom);
            run_decode(code, viterbi_ref(code), $sformatf("rnd_blk%0d", i), 1'b0, 0);
        end

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
